// File: rtl/pipe_hs_stage.sv
// pipe_hs_stage: DEPTH-stage elastic valid/ready pipeline register with flush and occupancy count.
// Define PIPE_HS_SKID_EN to add a 1-entry skid register that makes in_ready a flop output.
module pipe_hs_stage #(
    parameter int               WIDTH = 38,
    parameter int               DEPTH = 1,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       count
);
    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [3:0]       r_count;
    logic [DEPTH-1:0] w_adv;
    logic [DEPTH-1:0] w_load;
    logic [DEPTH-1:0] w_nxt_valid;
    logic [WIDTH-1:0] w_nxt_data [DEPTH];
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_src_valid;
    logic [WIDTH-1:0] w_src_data;

    // A stage may advance when the stage ahead is empty or itself advancing.
    always_comb begin
        w_adv = '0;
        w_adv[DEPTH-1] = out_ready;
        for (int k = DEPTH - 2; k >= 0; k--)
            w_adv[k] = !r_valid[k+1] | w_adv[k+1];
        w_load = ~r_valid | w_adv;
    end

    for (genvar s = 0; s < DEPTH; s++) begin : g_src
        if (s == 0) begin : g_first
            assign w_nxt_valid[s] = w_src_valid;
            assign w_nxt_data[s]  = w_src_data;
        end else begin : g_rest
            assign w_nxt_valid[s] = r_valid[s-1];
            assign w_nxt_data[s]  = r_data[s-1];
        end
    end

    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = r_valid[DEPTH-1] & out_ready;

`ifdef PIPE_HS_SKID_EN
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_in_ready;
    logic             w_skid_nxt;

    // The skid word always takes priority for stage 0, preserving order.
    assign in_ready    = r_in_ready & !flush;
    assign w_src_valid = r_skid_valid | w_in_xfer;
    assign w_src_data  = r_skid_valid ? r_skid_data : in_data;
    assign w_skid_nxt  = !w_load[0] & w_src_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_skid_valid <= 1'b0;
            r_skid_data  <= INIT;
            r_in_ready   <= 1'b1;
        end else if (flush) begin
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            r_skid_valid <= w_skid_nxt;
            r_in_ready   <= !w_skid_nxt;
            if (!r_skid_valid && w_in_xfer && !w_load[0])
                r_skid_data <= in_data;
        end
    end
`else
    assign in_ready    = !flush & w_load[0];
    assign w_src_valid = w_in_xfer;
    assign w_src_data  = in_data;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid <= '0;
            for (int k = 0; k < DEPTH; k++)
                r_data[k] <= INIT;
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= w_nxt_valid[k];
                    r_data[k]  <= w_nxt_data[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || flush)
            r_count <= '0;
        else
            r_count <= r_count + {3'b0, w_in_xfer} - {3'b0, w_out_xfer};
    end

    assign out_valid = r_valid[DEPTH-1];
    assign out_data  = r_data[DEPTH-1];
    assign count     = r_count;
endmodule

// File: tb/tb_pipe_hs_stage.sv
// tb_pipe_hs_stage: directed steps plus a random phase, with a queue scoreboard checking order and loss.
`timescale 1ns/1ps
module tb_pipe_hs_stage;
`ifdef PIPE_HS_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 3;
`endif
    localparam int               WIDTH = 38;
    localparam logic [WIDTH-1:0] INIT  = 38'h2A;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [3:0]       count;
    logic [WIDTH-1:0] sb [$];
    int               errs = 0;
    int               checks = 0;

    pipe_hs_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INIT(INIT)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 40 && (count != 0 || out_valid); n++) cyc();
        chk("drain_count", count, 0);
        chk("drain_sb_empty", sb.size(), 0);
    endtask

    // Scoreboard: transfers are decided at the negedge before the edge that performs them.
    always @(negedge clk) begin
        if (reset) begin
            chk("count_vs_sb", count, sb.size());
            if (out_valid && out_ready) begin
                chk("out_has_entry", sb.size() != 0, 1);
                if (sb.size() != 0) chk("out_order", out_data, sb.pop_front());
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back(in_data);
        end else begin
            sb.delete();
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) cyc();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, INIT);
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 1'b1;
        cyc();
        chk("rel_out_valid", out_valid, 0);
        chk("rel_out_data", out_data, INIT);
        chk("rel_count", count, 0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = WIDTH'(i);
            cyc();
            chk("stream_valid", out_valid, i >= DEPTH);
            if (i >= DEPTH) chk("stream_data", out_data, WIDTH'(i - DEPTH + 1));
            chk("stream_count", count, (i < DEPTH) ? i : DEPTH);
        end
`ifndef PIPE_HS_SKID_EN
        in_data   = 9;
        out_ready = 1'b0;
        #1;
        chk("bp_in_ready", in_ready, 0);
        repeat (5) begin
            cyc();
            chk("bp_hold_data", out_data, 6);
            chk("bp_hold_ready", in_ready, 0);
            chk("bp_hold_count", count, 3);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        for (int i = 10; i <= 12; i++) begin
            cyc();
            in_data = WIDTH'(i);
        end
        cyc();
`endif
        drain();
`ifndef PIPE_HS_SKID_EN
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 100;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        chk("bub_last_valid", out_valid, 1);
        in_valid = 1'b1;
        in_data  = 101;
        #1;
        chk("bub_ready_1", in_ready, 1);
        cyc();
        in_data = 102;
        #1;
        chk("bub_ready_2", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        chk("bub_count", count, 3);
        chk("bub_out_data", out_data, 100);
        drain();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 200;
        cyc();
        in_data = 201;
        cyc();
        chk("fl_count_before", count, 2);
        flush   = 1'b1;
        in_data = 202;
        #1;
        chk("fl_in_ready", in_ready, 0);
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", out_valid, 0);
        chk("fl_count", count, 0);
        out_ready = 1'b1;
        repeat (4) cyc();
        chk("fl_not_captured", out_valid, 0);
        chk("fl_count_after", count, 0);
`else
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = WIDTH'(300 + i);
            #1;
            chk("skid_accept_ready", in_ready, 1);
            cyc();
        end
        in_valid = 1'b0;
        chk("skid_full_ready", in_ready, 0);
        chk("skid_count", count, 3);
        out_ready = 1'b1;
        for (int n = 0; n < 3 && !in_ready; n++) cyc();
        chk("skid_ready_back", in_ready, 1);
        drain();
`endif
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 500;
        cyc();
        in_data = 501;
        cyc();
        reset = 1'b0;
        cyc();
        chk("mid_rst_count", count, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, INIT);
        chk("mid_rst_in_ready", in_ready, 1);
        reset    = 1'b1;
        in_valid = 1'b0;
        cyc();
        for (int i = 0; i < 400; i++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 39) == 0;
            in_data   = WIDTH'({$urandom, $urandom});
            cyc();
        end
        flush = 1'b0;
        drain();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
